// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU control stage: registered decode with stall/flush, RV32M codes and a busy counter.
// Optional M-extension support is enabled with `define ALU_CTRL_STAGE_RV32M_EN.
module alu_ctrl_stage #(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 34
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [2:0]        i_alu_op,
    input  logic              i_rtype,
    input  logic [2:0]        i_funct_3,
    input  logic              i_funct_7_5,
    input  logic              i_funct_7_0,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_valid_EX,
    output logic [CTRL_W-1:0] o_alu_ctrl_EX,
    output logic              o_multi_EX,
    output logic              o_illegal_EX
);

    typedef enum logic [2:0] {
        OP_LUI    = 3'd0,
        OP_ARITH  = 3'd1,
        OP_ADDSUB = 3'd2,
        OP_BRANCH = 3'd3,
        OP_ADD    = 3'd4
    } alu_op_e;

    typedef enum logic [4:0] {
        C_AND  = 5'd0,  C_OR   = 5'd1,  C_XOR  = 5'd2,  C_ADD  = 5'd3,
        C_SUB  = 5'd4,  C_SLL  = 5'd5,  C_SRL  = 5'd6,  C_SLT  = 5'd7,
        C_SLTU = 5'd8,  C_SRA  = 5'd9,  C_BEQ  = 5'd10, C_BNE  = 5'd11,
        C_BLT  = 5'd12, C_BLTU = 5'd13, C_BGE  = 5'd14, C_BGEU = 5'd15,
        C_LUI  = 5'd16, C_MUL  = 5'd17
    } ctrl_e;

    if (CTRL_W < 5 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_param_check
        $error("alu_ctrl_stage: CTRL_W must be >= 5 and latencies >= 1");
    end

    logic [4:0]        code5;
    logic              dec_ill;
    logic [CTRL_W-1:0] dec_code;
    logic              hold;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              illegal_q;

`ifdef ALU_CTRL_STAGE_RV32M_EN
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic             dec_m;
    logic [CNT_W-1:0] dec_lat;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             multi_q;
`endif

    always_comb begin
        code5   = C_ADD;
        dec_ill = 1'b0;
`ifdef ALU_CTRL_STAGE_RV32M_EN
        dec_m   = 1'b0;
        dec_lat = '0;
`endif
        case (i_alu_op)
            OP_LUI:    code5 = C_LUI;
            OP_ADD:    code5 = C_ADD;
            OP_ADDSUB: code5 = (i_funct_3 == 3'b000 && i_rtype && i_funct_7_5) ? C_SUB : C_ADD;
            OP_BRANCH: begin
                case (i_funct_3)
                    3'b000:  code5 = C_BEQ;
                    3'b001:  code5 = C_BNE;
                    3'b100:  code5 = C_BLT;
                    3'b101:  code5 = C_BGE;
                    3'b110:  code5 = C_BLTU;
                    3'b111:  code5 = C_BGEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_ARITH: begin
                if (i_rtype && i_funct_7_0) begin
`ifdef ALU_CTRL_STAGE_RV32M_EN
                    if (i_funct_7_5) begin
                        dec_ill = 1'b1;
                    end else begin
                        code5   = C_MUL + {2'b00, i_funct_3};
                        dec_m   = 1'b1;
                        dec_lat = i_funct_3[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                    end
`else
                    dec_ill = 1'b1;
`endif
                end else begin
                    case (i_funct_3)
                        3'b000:  code5 = (i_rtype && i_funct_7_5) ? C_SUB : C_ADD;
                        3'b001:  code5 = C_SLL;
                        3'b010:  code5 = C_SLT;
                        3'b011:  code5 = C_SLTU;
                        3'b100:  code5 = C_XOR;
                        3'b101:  code5 = i_funct_7_5 ? C_SRA : C_SRL;
                        3'b110:  code5 = C_OR;
                        default: code5 = C_AND;
                    endcase
                end
            end
            default: dec_ill = 1'b1;
        endcase
        dec_code = dec_ill ? '1 : CTRL_W'(code5);
    end

`ifdef ALU_CTRL_STAGE_RV32M_EN
    assign o_busy  = (cnt_q != '0);
    assign o_ready = (cnt_q <= CNT_W'(1)) && !i_stall;
    assign hold    = i_stall || (cnt_q > CNT_W'(1));

    // A load can only happen when cnt <= 1, so it always overrides the decrement.
    always_comb begin
        cnt_d = '0;
        if (i_flush) begin
            cnt_d = '0;
        end else if (i_valid && o_ready) begin
            cnt_d = dec_m ? dec_lat : '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            multi_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (i_flush) begin
                multi_q <= 1'b0;
            end else if (!hold) begin
                multi_q <= i_valid && dec_m;
            end
        end
    end

    assign o_multi_EX = multi_q;
`else
    assign o_busy     = 1'b0;
    assign o_ready    = !i_stall;
    assign hold       = i_stall;
    assign o_multi_EX = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_W'(C_ADD);
            illegal_q <= 1'b0;
        end else if (i_flush) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_W'(C_ADD);
            illegal_q <= 1'b0;
        end else if (!hold) begin
            if (i_valid) begin
                valid_q   <= 1'b1;
                ctrl_q    <= dec_code;
                illegal_q <= dec_ill;
            end else begin
                valid_q   <= 1'b0;
                ctrl_q    <= CTRL_W'(C_ADD);
                illegal_q <= 1'b0;
            end
        end
    end

    assign o_valid_EX    = valid_q;
    assign o_alu_ctrl_EX = ctrl_q;
    assign o_illegal_EX  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: table-driven reference model, directed and random stimulus.
// M-extension checks are included when ALU_CTRL_STAGE_RV32M_EN is defined.
module tb_alu_ctrl_stage;

    localparam int CTRL_W  = 5;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;
`ifdef ALU_CTRL_STAGE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid = 1'b0;
    logic [2:0] alu_op = 3'd0;
    logic rtype = 1'b0;
    logic [2:0] f3 = 3'd0;
    logic f75 = 1'b0;
    logic f70 = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;

    logic ready, busy, valid_ex, multi_ex, illegal_ex;
    logic [CTRL_W-1:0] ctrl_ex;

    int vectors = 0;
    int miscompares = 0;

    alu_ctrl_stage #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_alu_op(alu_op), .i_rtype(rtype),
        .i_funct_3(f3), .i_funct_7_5(f75), .i_funct_7_0(f70), .i_stall(stall), .i_flush(flush),
        .o_ready(ready), .o_busy(busy), .o_valid_EX(valid_ex), .o_alu_ctrl_EX(ctrl_ex),
        .o_multi_EX(multi_ex), .o_illegal_EX(illegal_ex)
    );

    always #5 clk = ~clk;

    // Decode tables indexed by funct3
    int arith_t[8]  = '{3, 5, 7, 8, 2, 6, 1, 0};
    int branch_t[8] = '{10, 11, 31, 31, 12, 14, 13, 15};

    function automatic void model_decode(input int op, input bit rt, input int fn3, input bit b75,
                                         input bit b70, output int code, output bit ill,
                                         output bit m, output int lat);
        code = 3; ill = 1'b0; m = 1'b0; lat = 0;
        if (op > 4) ill = 1'b1;
        else if (op == 0) code = 16;
        else if (op == 4) code = 3;
        else if (op == 2) code = (fn3 == 0 && rt && b75) ? 4 : 3;
        else if (op == 3) begin
            code = branch_t[fn3];
            ill = (code == 31);
        end else if (rt && b70) begin
            if (b75 || !M_EN) ill = 1'b1;
            else begin
                m = 1'b1;
                code = 17 + fn3;
                lat = (fn3 >= 4) ? DIV_LAT : MUL_LAT;
            end
        end else if (fn3 == 0) code = (rt && b75) ? 4 : 3;
        else if (fn3 == 5) code = b75 ? 9 : 6;
        else code = arith_t[fn3];
        if (ill) code = 31;
    endfunction

    // Model state: what EX holds and how many more cycles the current M-op keeps it busy
    bit m_valid, m_multi, m_ill;
    int m_ctrl, m_left;

    always @(posedge clk or posedge rst) begin
        int code, lat;
        bit ill, m;
        bool_blk: begin
            if (rst) begin
                m_valid = 0; m_ctrl = 3; m_multi = 0; m_ill = 0; m_left = 0;
            end else if (flush) begin
                m_valid = 0; m_ctrl = 3; m_multi = 0; m_ill = 0; m_left = 0;
            end else if (stall || m_left > 1) begin
                if (m_left > 0) m_left = m_left - 1;
            end else if (valid) begin
                model_decode(alu_op, rtype, f3, f75, f70, code, ill, m, lat);
                m_valid = 1; m_ctrl = code; m_multi = m; m_ill = ill; m_left = lat;
            end else begin
                m_valid = 0; m_ctrl = 3; m_multi = 0; m_ill = 0;
                if (m_left > 0) m_left = m_left - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("valid_EX", 32'(valid_ex), 32'(m_valid));
        chk("ctrl_EX", 32'(ctrl_ex), 32'(m_ctrl));
        chk("multi_EX", 32'(multi_ex), 32'(m_multi));
        chk("illegal_EX", 32'(illegal_ex), 32'(m_ill));
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("ready", 32'(ready), 32'(M_EN ? (m_left <= 1 && !stall) : !stall));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int op, input bit rt, input int fn3, input bit b75, input bit b70);
        valid = v; alu_op = 3'(op); rtype = rt; f3 = 3'(fn3); f75 = b75; f70 = b70;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_valid"}, 32'(valid_ex), 0);
        chk({nm, "_ctrl"}, 32'(ctrl_ex), 3);
        chk({nm, "_multi"}, 32'(multi_ex), 0);
        chk({nm, "_illegal"}, 32'(illegal_ex), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk_reset_vals("rst_init");
        chk("rst_init_ready", 32'(ready), 1);
        step();
        rst = 1'b0;

        drive(1, 1, 1, 0, 1, 0); step();
        chk("arith_sub", 32'(ctrl_ex), 4);
        chk("arith_sub_valid", 32'(valid_ex), 1);
        drive(1, 1, 0, 0, 1, 0); step();
        chk("arith_addi", 32'(ctrl_ex), 3);
        drive(1, 1, 0, 5, 1, 0); step();
        chk("srai", 32'(ctrl_ex), 9);
        drive(1, 3, 0, 6, 0, 0); step();
        chk("bltu", 32'(ctrl_ex), 13);
        drive(1, 3, 0, 2, 0, 0); step();
        chk("branch_hole", 32'(ctrl_ex), 31);
        chk("branch_hole_ill", 32'(illegal_ex), 1);
        drive(1, 6, 0, 0, 0, 0); step();
        chk("op110", 32'(ctrl_ex), 31);
        chk("op110_ill", 32'(illegal_ex), 1);
        drive(1, 1, 1, 0, 1, 1); step();
        chk("f7_both", 32'(ctrl_ex), 31);
        drive(0, 0, 0, 0, 0, 0); step();
        chk("bubble_ctrl", 32'(ctrl_ex), 3);

`ifdef ALU_CTRL_STAGE_RV32M_EN
        // DIV holds EX for DIV_LAT cycles, then the queued ADD appears
        drive(1, 1, 1, 4, 0, 1); step();
        drive(1, 4, 0, 0, 0, 0);
        for (int k = 1; k <= DIV_LAT; k++) begin
            chk("div_ctrl", 32'(ctrl_ex), 21);
            chk("div_busy", 32'(busy), 1);
            chk("div_ready", 32'(ready), 32'(k == DIV_LAT));
            step();
        end
        chk("div_next_ctrl", 32'(ctrl_ex), 3);
        chk("div_next_busy", 32'(busy), 0);
        chk("div_next_valid", 32'(valid_ex), 1);

        // MUL with stall in cycle 2: counter expires, EX holds MUL until stall drops
        drive(1, 1, 1, 0, 0, 1); step();
        chk("mul_ctrl", 32'(ctrl_ex), 17);
        chk("mul_multi", 32'(multi_ex), 1);
        drive(1, 4, 0, 0, 0, 0);
        chk("mul_c1_ready", 32'(ready), 0);
        step();
        stall = 1'b1; #1;
        chk("mul_c2_busy", 32'(busy), 1);
        chk("mul_c2_ready", 32'(ready), 0);
        step();
        chk("mul_c3_ctrl", 32'(ctrl_ex), 17);
        chk("mul_c3_busy", 32'(busy), 0);
        step();
        chk("mul_c4_ctrl", 32'(ctrl_ex), 17);
        stall = 1'b0; #1;
        chk("mul_c4_ready", 32'(ready), 1);
        step();
        chk("mul_after", 32'(ctrl_ex), 3);

        // Flush in cycle 5 of a DIV
        drive(1, 1, 1, 7, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) step();
        chk("flush_pre_busy", 32'(busy), 1);
        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_valid", 32'(valid_ex), 0);
        chk("flush_ctrl", 32'(ctrl_ex), 3);
        drive(1, 1, 1, 4, 0, 1);
`else
        drive(1, 1, 1, 0, 0, 1); step();
        chk("nom_mul_ctrl", 32'(ctrl_ex), 31);
        chk("nom_mul_ill", 32'(illegal_ex), 1);
        chk("nom_mul_busy", 32'(busy), 0);
        chk("nom_mul_multi", 32'(multi_ex), 0);
        drive(1, 1, 1, 2, 1, 0);
`endif
        // Asynchronous reset mid-operation
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_rst_valid", 32'(valid_ex), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        step();
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            rst = 1'b0;
            valid = ($urandom_range(0, 3) != 0);
            alu_op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rtype = 1'($urandom);
            f3 = 3'($urandom);
            f75 = 1'($urandom);
            f70 = 1'($urandom);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
            end
            step();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered successor of the combinational ALU control decoder: decodes `alu_op`, `funct3`, `funct7[5]` and `funct7[0]` into an ALU control code.
- Holds the code in an ID/EX pipeline register with stall and flush.
- Adds RV32M multiply/divide codes and flags undefined combinations explicitly.
- Sequences multi-cycle M-ops with a busy counter, so the EX-stage ALU and mul/div unit see a stable code for the whole operation.
- Sits between the main decoder (ID) and the ALU/mul-div unit (EX).

## Interface
Parameters:
- `CTRL_W`, default 5: width of the control code. Must be ≥5.
- `MUL_LAT`, default 2: cycles a MUL* code is held in EX. Must be ≥1.
- `DIV_LAT`, default 34: cycles a DIV*/REM* code is held in EX. Must be ≥1.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `i_valid`, in, 1: ID holds a valid instruction.
- `i_alu_op`, in, 3: 000 LUI, 001 ARITH, 010 ADD_SUB, 011 BRANCH, 100 ADD (JAL/JALR). 101–111 undefined.
- `i_rtype`, in, 1: instruction is R-type. Qualifies `funct7` use.
- `i_funct_3`, in, 3: funct3.
- `i_funct_7_5`, in, 1: funct7 bit 5.
- `i_funct_7_0`, in, 1: funct7 bit 0, the M-extension marker.
- `i_stall`, in, 1: hazard unit hold.
- `i_flush`, in, 1: insert bubble.
- `o_ready`, out, 1: ID may advance this cycle.
- `o_busy`, out, 1: multi-cycle op in progress.
- `o_valid_EX`, out, 1: EX register holds a valid op.
- `o_alu_ctrl_EX`, out, `CTRL_W`: control code.
- `o_multi_EX`, out, 1: held op is an M-op.
- `o_illegal_EX`, out, 1: undefined decode.

## Operation
Base codes:
- AND=0, OR=1, XOR=2, ADD=3, SUB=4, SLL=5, SRL=6, SLT=7, SLTU=8, SRA=9.
- BEQ=10, BNE=11, BLT=12, BLTU=13, BGE=14, BGEU=15, LUI=16.

Base mapping:
- ADD_SUB: funct3=000 gives SUB when `i_rtype & funct7_5`. Every other case gives ADD.
- ARITH, funct3=000: SUB when `i_rtype & funct7_5`, else ADD.
- ARITH, funct3=101: SRA when `funct7_5`, else SRL.
- ARITH, other funct3: SLL, SLT, SLTU, XOR, OR, AND in funct3 order.
- BRANCH: funct3 000/001/100/101/110/111 → BEQ/BNE/BLT/BGE/BLTU/BGEU. funct3 010/011 → illegal.
- LUI → LUI. ADD → ADD.

M-extension (`ALU_ARITH & i_rtype & funct7_0 & ~funct7_5`):
- MUL=17, MULH=18, MULHSU=19, MULHU=20, DIV=21, DIVU=22, REM=23, REMU=24, selected by funct3 000..111.
- funct3 0xx uses `MUL_LAT`. funct3 1xx uses `DIV_LAT`.

Illegal decode:
- Applies to alu_op 101–111, the branch holes, and R-type with funct7_0=1 and funct7_5=1.
- Gives code 31 (all ones) with `o_illegal_EX`=1. Never drives X/Z.

Control:
- `o_busy = (cnt != 0)`.
- `o_ready = (cnt <= 1) & ~i_stall`.
- Load condition: `load = i_valid & o_ready`.

Per-edge priority:
1. Reset.
2. Flush: bubble; `cnt` := 0.
3. Hold: when `i_stall`, or `cnt > 1`, the EX register is unchanged.
4. Load: capture the decode. `cnt` := MUL_LAT or DIV_LAT for an M-op, else 0.
5. Otherwise: bubble.

Bubble values: `valid`=0, `ctrl`=ADD(3), `multi`=0, `illegal`=0.

`cnt` decrements by 1 every cycle while nonzero and no flush or load occurs. Stall does not freeze `cnt`. `cnt` width is `$clog2(max(MUL_LAT,DIV_LAT)+1)`.

## Timing
- Reset values: `o_valid_EX`=0, `o_alu_ctrl_EX`=3, `o_multi_EX`=0, `o_illegal_EX`=0, `o_busy`=0, `cnt`=0. `o_ready`=1 while `i_stall`=0.
- Latency: a decode presented in cycle N appears on EX outputs in cycle N+1.
- An M-op with latency L is held on EX outputs for exactly L cycles.
  - `o_busy` is high for those L cycles.
  - The next instruction loads on the edge ending cycle L, so it is visible in cycle L+1.
- L=1 behaves as a single-cycle op: `o_ready` stays high.
- Flush while busy aborts the op. Next cycle: `o_busy`=0, `o_valid_EX`=0.
- Flush and stall together: flush wins.
- Reset asserted mid-operation clears all state asynchronously.

## Configuration
`ALU_CTRL_STAGE_RV32M_EN`:
- Defined: M-extension decode, `MUL_LAT`/`DIV_LAT` and the busy counter exist as described.
- Undefined: `i_funct_7_0`=1 with `i_rtype` under ARITH decodes as illegal (31). The counter is removed, `o_busy` is tied to 0, `o_multi_EX` is tied to 0, and `o_ready = ~i_stall`.

## Test plan
- Reset mid-run: assert `i_rst` asynchronously → all outputs reach reset values immediately, without waiting for a clock edge.
- ARITH, R-type, funct3=000, funct7_5=1, valid → next cycle ctrl=4, valid=1. With `i_rtype`=0 → ctrl=3.
- DIV (funct3=100, funct7_0=1), DIV_LAT=34 → ctrl=21 and busy held 34 cycles; `o_ready`=0 for cycles 1–33; following ADD appears in cycle 35.
- MUL with MUL_LAT=2, stall asserted in cycle 2 → counter still expires; EX holds MUL until stall drops.
- Flush at cycle 5 of a DIV → next cycle busy=0, valid=0, ctrl=3. Separately, alu_op=110 → ctrl=31, illegal=1.
- Build without `ALU_CTRL_STAGE_RV32M_EN`: MUL encoding → ctrl=31, illegal=1, busy stays 0.
